// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdm_pkg
// Description : Shared types and helpers for the 4-channel TDM data selector.
//               Channel count, the 2-bit channel index type, the slot FSM
//               state encoding and the mod-4 channel advance.
// Revision    : 1.0 - initial release
// ============================================================================
package tdm_pkg;

   localparam int NCH = 4;

   typedef logic [1:0] ch_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SLOT = 1'b1
   } state_t;

   // A 2-bit add wraps 3 -> 0 on its own, which is exactly the mod-4 advance.
   function automatic ch_t next_ch(input ch_t ptr);
      return ptr + 2'd1;
   endfunction

endpackage : tdm_pkg
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational round-robin search over four request lines.
//               Returns the first requesting channel at or after ptr_i in
//               circular order.
// Ports       : req_i   [3:0] per-channel request
//               ptr_i   [1:0] channel to start the search from
//               grant_o [1:0] selected channel (ptr_i when nothing found)
//               found_o       at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
   import tdm_pkg::*;
(
   input  logic [NCH-1:0] req_i,
   input  ch_t            ptr_i,
   output ch_t            grant_o,
   output logic           found_o
);

   ch_t idx;

   // Walk from the farthest offset down to offset 0 so the nearest
   // requesting channel is the last one to overwrite the grant.
   always_comb begin
      grant_o = ptr_i;
      found_o = 1'b0;
      idx     = ptr_i;
      for (int k = NCH - 1; k >= 0; k--) begin
         idx = ptr_i + ch_t'(k);
         if (req_i[idx]) begin
            grant_o = idx;
            found_o = 1'b1;
         end
      end
   end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/tdm_selector41.sv
`default_nettype none
// ============================================================================
// Module      : tdm_selector41
// Description : Time-division 4-to-1 data selector. Each slot selects one
//               channel, registers its data on oZ and its code on oS1/oS0,
//               pulses the channel acknowledge and marks channel-0 frames.
// Ports       : iClk, iRst         clock, synchronous active-high reset
//               iEn                advance enable (0 freezes the block)
//               iC0..iC3 [W-1:0]   channel data
//               iReq     [3:0]     per-channel request
//               oZ       [W-1:0]   selected data
//               oS1, oS0           selected channel code (oS1 = MSB)
//               oValid             oZ carries real data
//               oAck     [3:0]     one-cycle pulse on the served channel
//               oFrame             one-cycle pulse when a channel-0 slot opens
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_selector41
   import tdm_pkg::*;
#(
   parameter int W    = 1,
   parameter int HOLD = 1,
   parameter int SKIP = 0
)(
   input  logic           iClk,
   input  logic           iRst,
   input  logic           iEn,
   input  logic [W-1:0]   iC0,
   input  logic [W-1:0]   iC1,
   input  logic [W-1:0]   iC2,
   input  logic [W-1:0]   iC3,
   input  logic [NCH-1:0] iReq,
   output logic [W-1:0]   oZ,
   output logic           oS1,
   output logic           oS0,
   output logic           oValid,
   output logic [NCH-1:0] oAck,
   output logic           oFrame
);

   localparam logic [3:0] LAST_CNT = 4'(HOLD - 1);

   state_t         state_q, state_d;
   ch_t            ptr_q,   ptr_d;
   logic [3:0]     cnt_q,   cnt_d;
   logic [W-1:0]   z_q,     z_d;
   ch_t            s_q,     s_d;
   logic           valid_q, valid_d;
   logic [NCH-1:0] ack_q,   ack_d;
   logic           frame_q, frame_d;

   ch_t            grant;
   logic           found;    // a slot may open this cycle
   logic           req_ok;   // the opening slot carries real data
   logic [W-1:0]   chan_data;

   generate
      if (SKIP != 0) begin : g_rr
         rr_pick4 u_pick (
            .req_i   (iReq),
            .ptr_i   (ptr_q),
            .grant_o (grant),
            .found_o (found)
         );
         assign req_ok = found;
      end else begin : g_fixed
         // Fixed scan always opens the slot; an idle channel just gets an
         // empty (invalid) slot.
         assign grant  = ptr_q;
         assign found  = 1'b1;
         assign req_ok = iReq[ptr_q];
      end
   endgenerate

   always_comb begin
      chan_data = iC0;
      case (grant)
         2'd0:    chan_data = iC0;
         2'd1:    chan_data = iC1;
         2'd2:    chan_data = iC2;
         default: chan_data = iC3;
      endcase
   end

   // State register
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         z_q     <= '0;
         s_q     <= '0;
         valid_q <= 1'b0;
         ack_q   <= '0;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
         s_q     <= s_d;
         valid_q <= valid_d;
         ack_q   <= ack_d;
         frame_q <= frame_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      if (iEn) begin
         unique case (state_q)
            IDLE: begin
               if (found) begin
                  state_d = SLOT;
                  cnt_d   = '0;
               end
            end
            SLOT: begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == LAST_CNT) begin
                  // s_q holds the channel served in this slot.
                  state_d = IDLE;
                  ptr_d   = next_ch(s_q);
               end
            end
         endcase
      end
   end

   // Output logic: next values of the registered outputs. Acknowledge and
   // frame are single-cycle pulses, so they default to 0 every cycle.
   always_comb begin
      z_d     = z_q;
      s_d     = s_q;
      valid_d = valid_q;
      ack_d   = '0;
      frame_d = 1'b0;
      if (iEn && (state_q == IDLE)) begin
         if (found) begin
            s_d     = grant;
            valid_d = req_ok;
            z_d     = req_ok ? chan_data : '0;
            ack_d   = req_ok ? (4'b0001 << grant) : 4'b0000;
            frame_d = (grant == 2'd0);
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   assign oZ     = z_q;
   assign oS1    = s_q[1];
   assign oS0    = s_q[0];
   assign oValid = valid_q;
   assign oAck   = ack_q;
   assign oFrame = frame_q;

endmodule : tdm_selector41
`default_nettype wire
